control_decode_stage: RTL

- Registered RV32I/RV64I decode stage that sits between fetch and execute.
- Each accepted instruction is decoded into control signals plus a sign-extended immediate and held in an output pipeline register.
- Valid/ready handshake on both sides, with flush support and load-use hazard bubble insertion.
- Keeps instruction and stall performance counters.

---
 rtl/control_decode_stage.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/control_decode_stage.sv
// RV32I/RV64I decode stage: decodes one instruction per accept into a registered
// control bundle with valid/ready handshaking, flush, load-use bubbles and perf counters.
module control_decode_stage #(
  parameter int XLEN      = 32,
  parameter bit HAZARD_EN = 1'b1,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [2:0]       out_funct3,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_reg_write,
  output logic             out_mem_to_reg,
  output logic             out_store,
  output logic             out_branch,
  output logic [1:0]       out_op_a_sel,
  output logic             out_op_b_sel,
  output logic [2:0]       out_imm_sel,
  output logic [1:0]       out_next_pc_sel,
  output logic [3:0]       out_alu_op,
  output logic             out_illegal,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [6:0] {
    OPC_R     = 7'b0110011,
    OPC_I     = 7'b0010011,
    OPC_LOAD  = 7'b0000011,
    OPC_STORE = 7'b0100011,
    OPC_BR    = 7'b1100011,
    OPC_JAL   = 7'b1101111,
    OPC_JALR  = 7'b1100111,
    OPC_LUI   = 7'b0110111,
    OPC_AUIPC = 7'b0010111
  } opcode_e;

  logic [6:0]      opc;
  logic [4:0]      dec_rd, dec_rs1, dec_rs2;
  logic [2:0]      dec_f3;
  logic            d_rw, d_m2r, d_st, d_br, d_bsel, d_ill, use_rs1, use_rs2;
  logic [1:0]      d_asel, d_npc;
  logic [2:0]      d_isel;
  logic [3:0]      d_alu;
  logic [31:0]     imm32;
  logic [XLEN-1:0] d_imm;
  logic            hazard, accept, transfer, rs_hit;

  assign opc     = in_instr[6:0];
  assign dec_rd  = in_instr[11:7];
  assign dec_f3  = in_instr[14:12];
  assign dec_rs1 = in_instr[19:15];
  assign dec_rs2 = in_instr[24:20];

  always_comb begin
    d_rw    = 1'b0;
    d_m2r   = 1'b0;
    d_st    = 1'b0;
    d_br    = 1'b0;
    d_asel  = 2'b00;
    d_bsel  = 1'b0;
    d_isel  = 3'b000;
    d_npc   = 2'b00;
    d_alu   = 4'b0000;
    d_ill   = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (opc)
      OPC_R: begin
        d_rw    = 1'b1;
        d_alu   = {in_instr[30], dec_f3};
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OPC_I: begin
        d_rw    = 1'b1;
        d_bsel  = 1'b1;
        // only the shift-right pair uses bit 30 to pick arithmetic vs logical
        d_alu   = {(dec_f3 == 3'b101) ? in_instr[30] : 1'b0, dec_f3};
        use_rs1 = 1'b1;
      end
      OPC_LOAD: begin
        d_rw    = 1'b1;
        d_m2r   = 1'b1;
        d_bsel  = 1'b1;
        use_rs1 = 1'b1;
      end
      OPC_STORE: begin
        d_st    = 1'b1;
        d_bsel  = 1'b1;
        d_isel  = 3'b001;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OPC_BR: begin
        d_br    = 1'b1;
        d_isel  = 3'b010;
        d_npc   = 2'b01;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OPC_JAL: begin
        d_rw   = 1'b1;
        d_asel = 2'b01;
        d_bsel = 1'b1;
        d_isel = 3'b100;
        d_npc  = 2'b10;
      end
      OPC_JALR: begin
        d_rw    = 1'b1;
        d_bsel  = 1'b1;
        d_npc   = 2'b11;
        use_rs1 = 1'b1;
      end
      OPC_LUI: begin
        d_rw   = 1'b1;
        d_asel = 2'b10;
        d_bsel = 1'b1;
        d_isel = 3'b011;
      end
      OPC_AUIPC: begin
        d_rw   = 1'b1;
        d_asel = 2'b01;
        d_bsel = 1'b1;
        d_isel = 3'b011;
      end
      default: d_ill = 1'b1;
    endcase
  end

  always_comb begin
    imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
    case (d_isel)
      3'b001:  imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      3'b010:  imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                        in_instr[11:8], 1'b0};
      3'b011:  imm32 = {in_instr[31:12], 12'b0};
      3'b100:  imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                        in_instr[30:21], 1'b0};
      default: imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
    endcase
  end

  assign d_imm = XLEN'($signed(imm32));

  // load-use: the held load's destination feeds a source the incoming instruction reads
  assign rs_hit   = (use_rs1 && (dec_rs1 == out_rd)) || (use_rs2 && (dec_rs2 == out_rd));
  assign hazard   = HAZARD_EN && out_valid && out_mem_to_reg && (out_rd != 5'd0) &&
                    in_valid && rs_hit;
  assign in_ready = flush || ((!out_valid || out_ready) && !hazard);
  assign accept   = in_valid && in_ready && !flush;
  assign transfer = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (transfer)
        instr_cnt <= instr_cnt + CNT_W'(1);
      if (hazard && !flush)
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid       <= 1'b0;
      out_pc          <= '0;
      out_rd          <= '0;
      out_rs1         <= '0;
      out_rs2         <= '0;
      out_funct3      <= '0;
      out_imm         <= '0;
      out_reg_write   <= 1'b0;
      out_mem_to_reg  <= 1'b0;
      out_store       <= 1'b0;
      out_branch      <= 1'b0;
      out_op_a_sel    <= '0;
      out_op_b_sel    <= 1'b0;
      out_imm_sel     <= '0;
      out_next_pc_sel <= '0;
      out_alu_op      <= '0;
      out_illegal     <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid       <= 1'b1;
      out_pc          <= in_pc;
      out_rd          <= dec_rd;
      out_rs1         <= dec_rs1;
      out_rs2         <= dec_rs2;
      out_funct3      <= dec_f3;
      out_imm         <= d_imm;
      out_reg_write   <= d_rw && (dec_rd != 5'd0);
      out_mem_to_reg  <= d_m2r;
      out_store       <= d_st;
      out_branch      <= d_br;
      out_op_a_sel    <= d_asel;
      out_op_b_sel    <= d_bsel;
      out_imm_sel     <= d_isel;
      out_next_pc_sel <= d_npc;
      out_alu_op      <= d_alu;
      out_illegal     <= d_ill;
    end else if (transfer) begin
      out_valid <= 1'b0;
    end
  end

endmodule
